// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffq_bist.sv
// Pattern driver and checker wrapped around one dffq flop under test.
// Drives D from a 16-bit LFSR and checks Q two clocks later.
//
// Ports:
//   CLK, RST  clock; asynchronous active-high reset
//   START     begin a run (honoured in IDLE/DONE only)
//   LEN       number of patterns, sampled with an accepted START
//   D_OUT     registered drive to the flop's D
//   Q_IN      flop's Q
//   BUSY      high while patterns are driven or drained
//   DONE      high once the run has finished
//   FAIL      sticky, set on the first mismatch
//   ERR_CNT   saturating mismatch count
//   VDD, VSS  power pins, no function
//
// Build option: GF180_DFFQ_BIST_XCHECK_EN
//   defined   -> X/Z on Q_IN at a checked slot counts as a mismatch
//   undefined -> logical compare, X on Q_IN counts no error

module gf180mcu_fd_sc_mcu9t5v0__dffq_bist #(
  parameter int          CNT_W = 16,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [CNT_W-1:0] LEN,
  output logic             D_OUT,
  input  logic             Q_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAIL,
  output logic [CNT_W-1:0] ERR_CNT,
  input  logic             VDD,
  input  logic             VSS
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // An all-zero seed would lock the LFSR up.
  localparam logic [15:0] SEED_EFF =
    (SEED == 16'h0000) ? 16'h0001 : SEED;

  state_t           st;
  state_t           nxt;
  logic             accept;
  logic             run_en;
  logic [15:0]      lfsr;
  logic             fb;
  logic [CNT_W-1:0] rem;
  logic             drn;
  logic [1:0]       pv;
  logic [1:0]       pb;
  logic             mism;
  logic             d_q;
  logic             busy_q;
  logic             done_q;
  logic             fail_q;
  logic [CNT_W-1:0] err_q;
  logic             unused_pwr;

  assign unused_pwr = VDD ^ VSS;

  assign fb = lfsr[15] ^ lfsr[13]
            ^ lfsr[12] ^ lfsr[10];

  // pv/pb: index 0 is the head, index 1
  // the tail compared against Q_IN.
`ifdef GF180_DFFQ_BIST_XCHECK_EN
  assign mism = pv[1] && (Q_IN !== pb[1]);
`else
  assign mism = pv[1] && (Q_IN != pb[1]);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) st <= ST_IDLE;
    else     st <= nxt;
  end

  always_comb begin
    nxt    = st;
    accept = 1'b0;
    run_en = 1'b0;
    unique case (st)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          accept = 1'b1;
          nxt    = (LEN == '0) ? ST_DONE
                                : ST_RUN;
        end
      end
      ST_RUN: begin
        run_en = 1'b1;
        if (rem == CNT_W'(1))
          nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // drn marks the second drain cycle
        if (drn) nxt = ST_DONE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      d_q    <= 1'b0;
      lfsr   <= '0;
      rem    <= '0;
      drn    <= 1'b0;
      pv     <= '0;
      pb     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      fail_q <= 1'b0;
      err_q  <= '0;
    end else begin
      busy_q <= (nxt == ST_RUN) ||
                (nxt == ST_DRAIN);
      done_q <= (nxt == ST_DONE);
      drn    <= (st == ST_DRAIN) ? ~drn : 1'b0;
      pv     <= {pv[0], run_en};
      pb     <= {pb[0], run_en & lfsr[15]};
      if (run_en) begin
        d_q  <= lfsr[15];
        lfsr <= {lfsr[14:0], fb};
        rem  <= rem - CNT_W'(1);
      end
      if (accept) begin
        lfsr   <= SEED_EFF;
        rem    <= LEN;
        err_q  <= '0;
        fail_q <= 1'b0;
      end else if (mism) begin
        if (err_q != '1)
          err_q <= err_q + CNT_W'(1);
        fail_q <= 1'b1;
      end
    end
  end

  assign D_OUT   = d_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign FAIL    = fail_q;
  assign ERR_CNT = err_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dffq_bist.sv
// Scoreboard bench for the dffq BIST stage.
// Model DUTs: ideal flop, inverted flop, stuck-at-0.

module tb_gf180mcu_fd_sc_mcu9t5v0__dffq_bist;

  typedef struct {
    int err;
    int fl;
    int nb;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [15:0] len = '0;
  logic [3:0]  len2 = '0;
  logic        d_out, q_in = 1'b0;
  logic        busy, done, fail;
  logic [15:0] err_cnt;
  logic        d2, q2 = 1'b0;
  logic        busy2, done2, fail2;
  logic [3:0]  err2;
  logic        vdd = 1'b1;
  logic        vss = 1'b0;
  int          mode = 0;

  int errors = 0;
  int checks = 0;

  bit   pat_q[$];
  res_t res_q[$];

  gf180mcu_fd_sc_mcu9t5v0__dffq_bist #(
    .CNT_W(16), .SEED(16'hACE1)
  ) dut (
    .CLK(clk), .RST(rst), .START(start),
    .LEN(len), .D_OUT(d_out), .Q_IN(q_in),
    .BUSY(busy), .DONE(done), .FAIL(fail),
    .ERR_CNT(err_cnt), .VDD(vdd), .VSS(vss)
  );

  gf180mcu_fd_sc_mcu9t5v0__dffq_bist #(
    .CNT_W(4), .SEED(16'hACE1)
  ) dut4 (
    .CLK(clk), .RST(rst), .START(start2),
    .LEN(len2), .D_OUT(d2), .Q_IN(q2),
    .BUSY(busy2), .DONE(done2), .FAIL(fail2),
    .ERR_CNT(err2), .VDD(vdd), .VSS(vss)
  );

  always #5 clk = ~clk;

  // flop under test models
  always @(posedge clk) begin
    case (mode)
      1:       q_in <= ~d_out;
      2:       q_in <= 1'b0;
      default: q_in <= d_out;
    endcase
  end

  always @(posedge clk) q2 <= ~d2;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic bit [15:0] step(
    input bit [15:0] l);
    int v;
    int b;
    v = int'(l);
    b = ((v >> 15) ^ (v >> 13) ^
         (v >> 12) ^ (v >> 10)) & 1;
    return 16'(((v * 2) + b) % 65536);
  endfunction

  // monitor: patterns while busy, results on DONE rise
  int nbusy = 0;
  bit prev_done = 1'b0;

  always @(negedge clk) begin
    bit   e;
    res_t r;
    if (rst) begin
      nbusy     = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) begin
        if (nbusy > 0 && pat_q.size() > 0) begin
          e = pat_q.pop_front();
          chk("pattern", d_out, e);
        end
        nbusy++;
      end
      if (done && !prev_done) begin
        if (res_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          r = res_q.pop_front();
          chk("err_cnt", err_cnt, r.err);
          chk("fail", fail, r.fl);
          chk("busy_cycles", nbusy, r.nb);
        end
        nbusy = 0;
      end
      prev_done = done;
    end
  end

  task automatic run(input int n,
                     input int m,
                     input bit hold);
    bit [15:0] l;
    int   ones;
    int   edges;
    res_t r;
    l    = 16'hACE1;
    ones = 0;
    for (int k = 0; k < n; k++) begin
      pat_q.push_back(l[15]);
      if (l[15]) ones++;
      l = step(l);
    end
    r.err = (m == 1) ? n : (m == 2) ? ones : 0;
    r.fl  = (r.err != 0) ? 1 : 0;
    r.nb  = (n == 0) ? 0 : n + 2;
    res_q.push_back(r);
    mode  = m;
    len   = 16'(n);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    edges = 1;
    while (!done && edges < n + 10) begin
      @(posedge clk);
      #1;
      edges++;
    end
    start = 1'b0;
    chk("latency", edges,
        (n == 0) ? 1 : n + 3);
  endtask

  initial begin
    int n;
    int edges;
    repeat (2) @(negedge clk);
    chk("rst_d_out", d_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_err", err_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    run(0, 0, 0);
    run(100, 0, 0);
    run(20, 1, 0);
    run(64, 2, 0);
    run(10, 0, 1);

    // reset in the middle of a run
    mode  = 0;
    len   = 16'd50;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_d_out", d_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_fail", fail, 0);
    chk("mid_rst_err", err_cnt, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    run(8, 0, 0);

    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(1, 40);
      run(n, $urandom_range(0, 2), 1'b0);
    end

    // 4-bit counter instance, inverted flop
    len2   = 4'd15;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    edges  = 1;
    while (!done2 && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("w4_latency", edges, 18);
    chk("w4_err_cnt", err2, 15);
    chk("w4_fail", fail2, 1);

    repeat (3) @(negedge clk);
    chk("results_left", res_q.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
